adc_spi_scanner: RTL and testbench

- Parametrised successor to the ADC signal-capture/SCLK-divider pair. Divides CLOCK_50 into SCLK, frames SPI transfers with CS_N, and sends a channel address on MOSI each frame.
- Captures MISO into a shift register and sequences through a mask of enabled channels, either once or continuously.
- Handles the ADC's one-frame result pipeline: the data in frame k belongs to the channel addressed in frame k-1.
- Sits between the ADC pins and the sample consumer.

---
 rtl/adc_spi_scanner.sv | 197 +++++++++++++++++++
 tb/tb_adc_spi_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_scanner.sv
// SPI front end for a multi-channel ADC: divides CLOCK_50 into SCLK, frames each
// transfer with CS_N, addresses channels from a mask and realigns the ADC's one-frame result latency.
`timescale 1ns/1ps
module adc_spi_scanner #(
    parameter int CLK_DIV      = 4,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int NUM_CHANNELS = 8,
    parameter int GAP_CYCLES   = 4,
    localparam int ADDR_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    resetN,
    input  logic                    start,
    input  logic                    continuous,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    output logic                    SCLK,
    output logic                    CS_N,
    output logic                    MOSI,
    input  logic                    MISO,
    output logic [DATA_BITS-1:0]    sample_data,
    output logic [ADDR_BITS-1:0]    sample_channel,
    output logic                    sample_valid,
    output logic                    busy
);

    localparam int HALF    = CLK_DIV / 2;
    localparam int CNT_MAX = (GAP_CYCLES > HALF) ? GAP_CYCLES : HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = $clog2(CLK_DIV);
    localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(HALF);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic                    cont_q, cont_d;
    logic [ADDR_BITS-1:0]    cur_ch_q, cur_ch_d;
    logic [ADDR_BITS-1:0]    prev_ch_q, prev_ch_d;
    logic                    pending_q, pending_d;
    logic                    flush_q, flush_d;
    logic [DATA_BITS-1:0]    sample_data_q, sample_data_d;
    logic [ADDR_BITS-1:0]    sample_channel_q, sample_channel_d;
    logic                    sample_valid_q, sample_valid_d;

    logic [ADDR_BITS-1:0]    start_low, wrap_low, above_ch, mosi_sh;
    logic                    has_above, stop;

    // Channel search: lowest bit of the incoming/latched mask and the next bit above cur_ch.
    always_comb begin
        start_low = '0;
        wrap_low  = '0;
        above_ch  = '0;
        has_above = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (channel_mask[i]) start_low = ADDR_BITS'(i);
            if (mask_q[i]) wrap_low = ADDR_BITS'(i);
            if (mask_q[i] && i > int'(cur_ch_q)) begin
                above_ch  = ADDR_BITS'(i);
                has_above = 1'b1;
            end
        end
    end

    assign stop = cont_q ? !continuous : !has_above;

    always_ff @(posedge CLOCK_50) begin
        if (!resetN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && (|channel_mask)) state_d = S_SETUP;
            S_SETUP: if (cnt_q == HALF_LAST) state_d = S_SHIFT;
            S_SHIFT: if (phase_q == PH_LAST && bit_cnt_q == BIT_LAST) state_d = S_HOLD;
            S_HOLD:  if (cnt_q == HALF_LAST) state_d = S_GAP;
            S_GAP:   if (cnt_q == GAP_LAST) state_d = flush_q ? S_IDLE : S_SETUP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mosi_sh = cur_ch_q << bit_cnt_q;
        SCLK    = (state_q == S_SHIFT) && (phase_q >= PH_RISE);
        CS_N    = !(state_q inside {S_SETUP, S_SHIFT, S_HOLD});
        MOSI    = (state_q inside {S_SETUP, S_SHIFT}) ? mosi_sh[ADDR_BITS-1] : 1'b0;
        busy    = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d            = '0;
        phase_d          = '0;
        bit_cnt_d        = '0;
        shift_d          = shift_q;
        mask_d           = mask_q;
        cont_d           = cont_q;
        cur_ch_d         = cur_ch_q;
        prev_ch_d        = prev_ch_q;
        pending_d        = pending_q;
        flush_d          = flush_q;
        sample_data_d    = sample_data_q;
        sample_channel_d = sample_channel_q;
        sample_valid_d   = 1'b0;

        if (state_d == state_q && (state_q inside {S_SETUP, S_HOLD, S_GAP}))
            cnt_d = cnt_q + CNT_ONE;

        if (state_q == S_SHIFT && phase_q == PH_RISE)
            shift_d = {shift_q[DATA_BITS-2:0], MISO};

        if (state_q == S_SHIFT && state_d == S_SHIFT) begin
            phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
            bit_cnt_d = (phase_q == PH_LAST) ? bit_cnt_q + BIT_ONE : bit_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (state_d == S_SETUP) begin
                    mask_d    = channel_mask;
                    cont_d    = continuous;
                    cur_ch_d  = start_low;
                    pending_d = 1'b0;
                    flush_d   = 1'b0;
                end
            end
            // This frame carries the previous frame's channel result.
            S_SHIFT: begin
                if (state_d == S_HOLD) begin
                    sample_valid_d = pending_q;
                    if (pending_q) begin
                        sample_data_d    = shift_d;
                        sample_channel_d = prev_ch_q;
                    end
                    pending_d = 1'b1;
                    prev_ch_d = cur_ch_q;
                end
            end
            S_GAP: begin
                if (state_d == S_SETUP) begin
                    if (stop) flush_d  = 1'b1;
                    else      cur_ch_d = has_above ? above_ch : wrap_low;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetN) begin
            cnt_q            <= '0;
            phase_q          <= '0;
            bit_cnt_q        <= '0;
            pending_q        <= 1'b0;
            flush_q          <= 1'b0;
            sample_data_q    <= '0;
            sample_channel_q <= '0;
            sample_valid_q   <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            phase_q          <= phase_d;
            bit_cnt_q        <= bit_cnt_d;
            pending_q        <= pending_d;
            flush_q          <= flush_d;
            sample_data_q    <= sample_data_d;
            sample_channel_q <= sample_channel_d;
            sample_valid_q   <= sample_valid_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        shift_q   <= shift_d;
        mask_q    <= mask_d;
        cont_q    <= cont_d;
        cur_ch_q  <= cur_ch_d;
        prev_ch_q <= prev_ch_d;
    end

    assign sample_data    = sample_data_q;
    assign sample_channel = sample_channel_q;
    assign sample_valid   = sample_valid_q;

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Bench for adc_spi_scanner: an ADC model answering with last frame's channel word,
// and a scoreboard predicting frame addresses and results from the channel mask.
`timescale 1ns/1ps
module tb_adc_spi_scanner;

    localparam int CLK_DIV    = 4;
    localparam int FRAME_BITS = 16;
    localparam int GAP_CYCLES = 4;
    localparam int HALF       = CLK_DIV / 2;
    localparam int FRAME_CYC  = CLK_DIV + FRAME_BITS * CLK_DIV + GAP_CYCLES;

    logic        CLOCK_50 = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  channel_mask = 8'h00;
    logic        MISO;
    logic        SCLK, CS_N, MOSI;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic        sample_valid, busy;

    adc_spi_scanner dut (
        .CLOCK_50       (CLOCK_50),
        .resetN         (resetN),
        .start          (start),
        .continuous     (continuous),
        .channel_mask   (channel_mask),
        .SCLK           (SCLK),
        .CS_N           (CS_N),
        .MOSI           (MOSI),
        .MISO           (MISO),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .sample_valid   (sample_valid),
        .busy           (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ADC model: shifts out the word of the channel addressed in the previous frame.
    logic [15:0] adc_val [8];
    logic [15:0] word = '0;
    logic [15:0] mosi_bits = '0;
    logic [2:0]  cur_addr = '0;
    logic [2:0]  last_addr = '0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    int          bitn = 0;
    int          rises = 0;
    int          frames_started = 0;
    int          aborted = 0;
    int          mosi_tail_err = 0;
    int          addr_q[$];

    always @(CS_N or SCLK) begin
        if (CS_N != cs_prev) begin
            if (!CS_N) begin
                frames_started++;
                word      = adc_val[last_addr];
                bitn      = 0;
                rises     = 0;
                mosi_bits = '0;
                MISO      = word[15];
            end else begin
                if (rises >= 3) last_addr = cur_addr;
                if (rises == FRAME_BITS) begin
                    addr_q.push_back(int'(cur_addr));
                    if (mosi_bits[12:0] != 13'd0) mosi_tail_err++;
                end else begin
                    aborted++;
                end
            end
        end
        if (SCLK != sclk_prev && !CS_N) begin
            if (SCLK) begin
                mosi_bits = {mosi_bits[14:0], MOSI};
                rises++;
                if (rises == 3) cur_addr = mosi_bits[2:0];
            end else begin
                bitn++;
                if (bitn < 16) MISO = word[15 - bitn];
            end
        end
        cs_prev   = CS_N;
        sclk_prev = SCLK;
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int busy_cyc = 0;
    int sclk_err = 0;
    int gap_err = 0;
    int low_run = 0;
    int high_run = 0;
    int cs_high_run = 100;
    bit first_rise = 1'b1;
    int vq_ch[$];
    int vq_data[$];
    int vq_cyc[$];

    always @(negedge CLOCK_50) begin
        if (busy) busy_cyc <= busy_cyc + 1;
        if (sample_valid) begin
            vq_ch.push_back(int'(sample_channel));
            vq_data.push_back(int'(sample_data));
            vq_cyc.push_back(cyc);
        end
        if (CS_N) begin
            low_run     <= 0;
            high_run    <= 0;
            first_rise  <= 1'b1;
            cs_high_run <= cs_high_run + 1;
        end else begin
            if (cs_high_run > 0 && cs_high_run < GAP_CYCLES) gap_err <= gap_err + 1;
            cs_high_run <= 0;
            if (SCLK) begin
                if (low_run > 0) begin
                    if (!(low_run == HALF || (first_rise && low_run == CLK_DIV)))
                        sclk_err <= sclk_err + 1;
                    first_rise <= 1'b0;
                end
                low_run  <= 0;
                high_run <= high_run + 1;
            end else begin
                if (high_run > 0 && high_run != HALF) sclk_err <= sclk_err + 1;
                high_run <= 0;
                low_run  <= low_run + 1;
            end
        end
    end

    task automatic fill_adc();
        for (int i = 0; i < 8; i++) adc_val[i] = 16'($urandom);
    endtask

    // One scan from start to idle; R data frames plus one flush frame are expected.
    task automatic run_scan(input string tag, input logic [7:0] mask, input bit cont,
                            input int drop_frame, input bit poke_start);
        int v0, a0, b0, f0, s0, g0, ab0, t0, k, r, n, c, ea;
        int en[$];
        v0 = vq_ch.size(); a0 = addr_q.size(); b0 = busy_cyc; f0 = frames_started;
        s0 = sclk_err; g0 = gap_err; ab0 = aborted; t0 = mosi_tail_err;
        for (int i = 0; i < 8; i++) if (mask[i]) en.push_back(i);
        k = en.size();
        r = cont ? drop_frame : k;
        @(negedge CLOCK_50);
        start = 1'b1; channel_mask = mask; continuous = cont;
        @(negedge CLOCK_50);
        start = 1'b0; channel_mask = 8'($urandom);
        if (poke_start) begin
            repeat (30) @(negedge CLOCK_50);
            start = 1'b1; channel_mask = 8'hFF; continuous = 1'b1;
            @(negedge CLOCK_50);
            start = 1'b0; continuous = cont;
        end
        if (cont) begin
            n = 0;
            while (frames_started - f0 < drop_frame && n < 2000) begin
                @(negedge CLOCK_50); n++;
            end
            repeat (20) @(negedge CLOCK_50);
            continuous = 1'b0;
        end
        n = 0;
        while (busy && n < (r + 3) * FRAME_CYC) begin
            @(negedge CLOCK_50); n++;
        end
        repeat (2) @(negedge CLOCK_50);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_busy_cycles"}, busy_cyc - b0, (r + 1) * FRAME_CYC);
        chk({tag, "_frames"}, frames_started - f0, r + 1);
        chk({tag, "_valid_count"}, vq_ch.size() - v0, r);
        for (int i = 0; i < r && v0 + i < vq_ch.size(); i++) begin
            c = en[i % k];
            chk({tag, "_ch"}, vq_ch[v0 + i], c);
            chk({tag, "_data"}, vq_data[v0 + i], int'(adc_val[c][11:0]));
            if (i > 0) chk({tag, "_spacing"}, vq_cyc[v0 + i] - vq_cyc[v0 + i - 1], FRAME_CYC);
        end
        chk({tag, "_addr_count"}, addr_q.size() - a0, r + 1);
        for (int i = 0; i <= r && a0 + i < addr_q.size(); i++) begin
            ea = (i < r) ? en[i % k] : en[(r - 1) % k];
            chk({tag, "_mosi_addr"}, addr_q[a0 + i], ea);
        end
        chk({tag, "_mosi_tail"}, mosi_tail_err - t0, 0);
        chk({tag, "_sclk_shape"}, sclk_err - s0, 0);
        chk({tag, "_cs_gap"}, gap_err - g0, 0);
        chk({tag, "_partial_frames"}, aborted - ab0, 0);
    endtask

    task automatic reset_mid_shift(input logic [7:0] mask);
        int v0, f0, ab0, n;
        v0 = vq_ch.size(); f0 = frames_started; ab0 = aborted;
        @(negedge CLOCK_50);
        start = 1'b1; channel_mask = mask; continuous = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        n = 0;
        while ((frames_started - f0 < 2 || rises < 8) && n < 1000) begin
            @(negedge CLOCK_50); n++;
        end
        resetN = 1'b0;
        @(posedge CLOCK_50);
        #1;
        chk("rst_mid_csn", int'(CS_N), 1);
        chk("rst_mid_sclk", int'(SCLK), 0);
        chk("rst_mid_valid", int'(sample_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        repeat (3) @(negedge CLOCK_50);
        resetN = 1'b1; continuous = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        chk("rst_mid_no_valid", vq_ch.size() - v0, 0);
        chk("rst_mid_partial", aborted - ab0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] m;
        fill_adc();
        repeat (4) @(negedge CLOCK_50);
        resetN = 1'b1;
        @(negedge CLOCK_50);
        chk("reset_sclk", int'(SCLK), 0);
        chk("reset_csn", int'(CS_N), 1);
        chk("reset_mosi", int'(MOSI), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_data", int'(sample_data), 0);
        chk("reset_channel", int'(sample_channel), 0);

        start = 1'b1; channel_mask = 8'h00;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        chk("zero_mask_busy", int'(busy), 0);
        chk("zero_mask_csn", int'(CS_N), 1);

        fill_adc();
        adc_val[2] = 16'h0ABC;
        run_scan("single", 8'b0000_0100, 1'b0, 0, 1'b0);

        for (int i = 0; i < 8; i++) adc_val[i] = {4'($urandom), 12'h100 + 12'(i)};
        run_scan("multi", 8'b1000_0011, 1'b0, 0, 1'b1);

        fill_adc();
        run_scan("cont", 8'b0000_0011, 1'b1, 10, 1'b0);

        for (int t = 0; t < 4; t++) begin
            fill_adc();
            m = 8'($urandom_range(1, 255));
            run_scan("rand", m, 1'($urandom), $urandom_range(1, 6), 1'($urandom));
        end

        fill_adc();
        reset_mid_shift(8'b0101_0110);
        m = 8'($urandom_range(1, 255));
        run_scan("after_reset", m, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
